dmem_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing the single-port data memory among N_REQ

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 35 +++
 rtl/dmem_arbiter_rr_picker.sv | 36 +++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Mask codes follow the load/store funct3 size/sign encoding.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signal bundle of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_wr;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*3-1:0]      req_mask;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic                    busy;

  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [2:0]              mem_mask;
  logic                    mem_wr_en;
  logic                    mem_rd_en;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, req_mask, mem_rdata,
    output ack, rdata, busy, mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, req_mask, mem_rdata,
    input  ack, rdata, busy, mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0. Returns one-hot grant and its index.
module rr_picker
  import dmem_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = IW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer sharing one single-port data memory among N_REQ requesters:
// IDLE picks and latches a winner, ACCESS drives the memory for a full clock, RESP acks.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  localparam int IW = idx_w(N_REQ);

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [2:0]        mask_arr  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
      assign mask_arr[gi]  = bus.req_mask[gi*3 +: 3];
    end
  endgenerate

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        mask_q, mask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are captured in IDLE so a requester dropping req later cannot cancel.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          idx_d   = pick_idx;
          gnt_d   = pick_gnt;
          wr_d    = bus.req_wr[pick_idx];
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          mask_d  = mask_arr[pick_idx];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = wr_q ? '0 : bus.mem_rdata;
        ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory controls decode straight from state so an async reset drops them at once.
  always_comb begin
    bus.ack       = '0;
    bus.busy      = (state_q != IDLE);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_mask  = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_rd_en = 1'b0;
    case (state_q)
      ACCESS: begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_mask  = mask_q;
        bus.mem_wr_en = wr_q;
        bus.mem_rd_en = !wr_q;
      end
      RESP: begin
        bus.ack = gnt_q;
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural sub-word data memory
// (combinational read, negedge write) attached to the memory port.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;
  int   acc_cnt = 0;
  int   snap_ack;
  int   snap_acc;

  logic [31:0] mem_arr [0:255];

  dmem_arbiter_if #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * off));
    h = off[1] ? w[31:16] : w[15:0];
    case (m)
      MASK_B:  return {{24{b[7]}}, b};
      MASK_H:  return {{16{h[15]}}, h};
      MASK_BU: return {24'd0, b};
      MASK_HU: return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    bus.mem_rdata = mem_read(mem_arr[bus.mem_addr[9:2]], bus.mem_addr[1:0], bus.mem_mask);
  end

  always @(negedge clk) begin
    if (bus.ack != 2'b00) ack_cnt++;
    if (bus.mem_wr_en || bus.mem_rd_en) acc_cnt++;
    if (bus.mem_wr_en) begin
      case (bus.mem_mask)
        MASK_B:  mem_arr[bus.mem_addr[9:2]][8*bus.mem_addr[1:0] +: 8] = bus.mem_wdata[7:0];
        MASK_H:  mem_arr[bus.mem_addr[9:2]][16*bus.mem_addr[1] +: 16] = bus.mem_wdata[15:0];
        default: mem_arr[bus.mem_addr[9:2]] = bus.mem_wdata;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] m);
    bus.req[i]              = 1'b1;
    bus.req_wr[i]           = wr;
    bus.req_addr[i*32 +: 32]  = a;
    bus.req_wdata[i*32 +: 32] = d;
    bus.req_mask[i*3 +: 3]    = m;
  endtask

  task automatic clr_req(input int i);
    bus.req[i] = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_mask  = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
    mem_arr[8'h20] = 32'h0000A5FF;   // byte addr 0x80
    mem_arr[8'h08] = 32'h11112222;   // byte addr 0x20
    mem_arr[8'h09] = 32'h33334444;   // byte addr 0x24
    mem_arr[8'h0C] = 32'h55556666;   // byte addr 0x30

    #2;
    chk("rst_ack",   32'(bus.ack), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_addr",  bus.mem_addr, 32'd0);
    chk("rst_en",    {30'd0, bus.mem_wr_en, bus.mem_rd_en}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset asserted in the middle of an ACCESS cycle
    set_req(0, 1'b1, 32'h40, 32'hCAFEF00D, MASK_W);
    tick();
    chk("t1_wr_en", 32'(bus.mem_wr_en), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t1_busy",  32'(bus.busy), 32'd0);
    chk("t1_wr_off", 32'(bus.mem_wr_en), 32'd0);
    chk("t1_addr0", bus.mem_addr, 32'd0);
    chk("t1_wdata0", bus.mem_wdata, 32'd0);
    chk("t1_ack0",  32'(bus.ack), 32'd0);
    snap_ack = ack_cnt;
    clr_req(0);
    #3 reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t1_no_ack", 32'(ack_cnt - snap_ack), 32'd0);
    chk("t1_no_write", mem_arr[8'h10], 32'd0);

    // Single store then load back
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, MASK_W);
    tick();
    chk("t2_wr_en", 32'(bus.mem_wr_en), 32'd1);
    chk("t2_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("t2_addr",  bus.mem_addr, 32'h10);
    chk("t2_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("t2_mask",  32'(bus.mem_mask), 32'd2);
    chk("t2_ack_early", 32'(bus.ack), 32'd0);
    tick();
    chk("t2_ack", 32'(bus.ack), 32'd1);
    chk("t2_wr_off", 32'(bus.mem_wr_en), 32'd0);
    chk("t2_addr_off", bus.mem_addr, 32'd0);
    chk("t2_st_rdata", bus.rdata, 32'd0);
    clr_req(0);
    tick();
    chk("t2_idle_ack", 32'(bus.ack), 32'd0);
    chk("t2_idle_busy", 32'(bus.busy), 32'd0);
    chk("t2_mem", mem_arr[8'h04], 32'hDEADBEEF);
    set_req(0, 1'b0, 32'h10, 32'h0, MASK_W);
    tick();
    chk("t2_ld_rd_en", 32'(bus.mem_rd_en), 32'd1);
    chk("t2_ld_wr_en", 32'(bus.mem_wr_en), 32'd0);
    tick();
    chk("t2_ld_ack",   32'(bus.ack), 32'd1);
    chk("t2_ld_rdata", bus.rdata, 32'hDEADBEEF);
    clr_req(0);
    tick();

    // Signed byte load by requester 1
    set_req(1, 1'b0, 32'h81, 32'h0, MASK_B);
    tick();
    chk("t3_addr", bus.mem_addr, 32'h81);
    chk("t3_mask", 32'(bus.mem_mask), 32'd0);
    tick();
    chk("t3_ack",   32'(bus.ack), 32'd2);
    chk("t3_rdata", bus.rdata, 32'hFFFFFFA5);
    clr_req(1);
    tick();

    // Continuous contention from a fresh pointer
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    set_req(0, 1'b0, 32'h20, 32'h0, MASK_W);
    set_req(1, 1'b0, 32'h24, 32'h0, MASK_W);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("t4_addr%0d", t), bus.mem_addr, (t % 2 == 1) ? 32'h24 : 32'h20);
      tick();
      chk($sformatf("t4_ack%0d", t), 32'(bus.ack), (t % 2 == 1) ? 32'd2 : 32'd1);
      chk($sformatf("t4_rdata%0d", t), bus.rdata, (t % 2 == 1) ? 32'h33334444 : 32'h11112222);
      tick();
      chk($sformatf("t4_idle%0d", t), 32'(bus.busy), 32'd0);
    end
    clr_req(0);
    clr_req(1);
    tick();

    // Requester 0 back to back, requester 1 arrives during the first access
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    set_req(0, 1'b0, 32'h20, 32'h0, MASK_W);
    tick();
    chk("t5_addr_a", bus.mem_addr, 32'h20);
    set_req(1, 1'b0, 32'h24, 32'h0, MASK_W);
    tick();
    chk("t5_ack_a", 32'(bus.ack), 32'd1);
    tick();
    tick();
    chk("t5_addr_b", bus.mem_addr, 32'h24);
    tick();
    chk("t5_ack_b",   32'(bus.ack), 32'd2);
    chk("t5_rdata_b", bus.rdata, 32'h33334444);
    clr_req(1);
    tick();
    tick();
    chk("t5_addr_c", bus.mem_addr, 32'h20);
    tick();
    chk("t5_ack_c",   32'(bus.ack), 32'd1);
    chk("t5_rdata_c", bus.rdata, 32'h11112222);
    clr_req(0);
    tick();

    // Request dropped after it has been latched
    snap_ack = ack_cnt;
    snap_acc = acc_cnt;
    set_req(1, 1'b0, 32'h30, 32'h0, MASK_W);
    tick();
    clr_req(1);
    tick();
    chk("t6_ack",   32'(bus.ack), 32'd2);
    chk("t6_rdata", bus.rdata, 32'h55556666);
    tick();
    tick();
    tick();
    chk("t6_one_access", 32'(acc_cnt - snap_acc), 32'd1);
    chk("t6_one_ack",    32'(ack_cnt - snap_ack), 32'd1);
    chk("t6_busy",       32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
